// File: rtl/memory_responder.sv
// ---------------------------------------------------------------------------
// memory_responder
//
// Word-addressed single-port RAM that answers the CPU memory port.
// After reset a clear sweep writes zero to every word, one word per clock,
// and `ready` stays low until the sweep has written the last word. Once
// ready, every clock performs one access at `addr`:
//   we=1 : mem[addr] <= data, out <= previous mem[addr]  (read-first)
//   we=0 : out <= mem[addr]
// Read data is registered, so it appears on `out` one clock after `addr`.
//
// Optional feature (compile-time macro MEMORY_PARITY_EN):
//   Each stored word carries an extra even-parity bit. The bit is written as
//   ^data on every write and as 0 by the clear sweep. Every read with we=0 is
//   checked one clock after `out` is updated. A mismatch sets the sticky
//   `parity_err` flag, which only rst_n clears. Without the macro there is
//   no parity storage and no `parity_err` port.
//
// Ports
//   clk        in   1           clock, all state updates on posedge
//   rst_n      in   1           asynchronous, active-low reset
//   we         in   1           write enable for this cycle's addr/data
//   addr       in   ADDR_WIDTH  word address (read or write)
//   data       in   DATA_WIDTH  write data, used only when we=1
//   out        out  DATA_WIDTH  registered read data
//   ready      out  1           1 = clear sweep finished, requests accepted
//   parity_err out  1           sticky parity error (MEMORY_PARITY_EN only)
// ---------------------------------------------------------------------------
module memory_responder #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  ready
`ifdef MEMORY_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef MEMORY_PARITY_EN
    localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
    localparam int WORD_WIDTH = DATA_WIDTH;
`endif

    // FSM encoding
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    // Terminal sweep address: detected by compare, the counter itself is
    // free to wrap afterwards because it is no longer used in READY.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]            state_reg;
    logic [0:0]            state_next;
    logic [ADDR_WIDTH-1:0] clr_addr_reg;
    logic [ADDR_WIDTH-1:0] clr_addr_next;

    // Storage array; no reset so it maps onto block RAM.
    logic [WORD_WIDTH-1:0] mem [DEPTH];

    // Single write port shared by the clear sweep and CPU writes.
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] wr_word;

    // Registered read word (includes the parity bit when present).
    logic [WORD_WIDTH-1:0] rd_word_reg;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        if (state_reg == CLEAR) begin
            clr_addr_next = clr_addr_reg + ADDR_WIDTH'(1);
            if (clr_addr_reg == LAST_ADDR) begin
                state_next = READY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    assign ready = (state_reg == READY);

    // -----------------------------------------------------------------------
    // Write-port mux: the sweep owns the port while clearing, so any CPU
    // write issued during CLEAR is simply dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_word = '0;
        if (state_reg == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr_reg;
            wr_word = '0;
        end else begin
            wr_en   = we;
            wr_addr = addr;
`ifdef MEMORY_PARITY_EN
            wr_word = {^data, data};
`else
            wr_word = data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // -----------------------------------------------------------------------
    // Registered read. The non-blocking update of mem above means a read of
    // the address being written returns the old contents (read-first).
    // While clearing, the output is held at zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_word_reg <= '0;
        end else if (state_reg == CLEAR) begin
            rd_word_reg <= '0;
        end else begin
            rd_word_reg <= mem[addr];
        end
    end

    assign out = rd_word_reg[DATA_WIDTH-1:0];

`ifdef MEMORY_PARITY_EN
    // -----------------------------------------------------------------------
    // Parity check, pipelined one stage behind the read register so the
    // check works on the registered word instead of an asynchronous array
    // read. rd_check_reg marks that rd_word_reg holds a plain READY read.
    // -----------------------------------------------------------------------
    logic rd_check_reg;
    logic parity_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_check_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            rd_check_reg   <= (state_reg == READY) && !we;
            // Even parity: a healthy word XORs to zero across all bits.
            parity_err_reg <= parity_err_reg | (rd_check_reg & (^rd_word_reg));
        end
    end

    assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_memory_responder
//
// Directed testbench for memory_responder (ADDR_WIDTH=6, DATA_WIDTH=16).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, away from the active edge. Expected values are fixed
// constants worked out by hand from the intended behaviour.
// Build with +define+MEMORY_PARITY_EN to also cover the parity feature.
// ---------------------------------------------------------------------------
module tb_memory_responder;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 64;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] out;
    logic          ready;
`ifdef MEMORY_PARITY_EN
    logic          parity_err;
`endif

    int errors = 0;
    int checks = 0;

    memory_responder #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .addr      (addr),
        .data      (data),
        .out       (out),
        .ready     (ready)
`ifdef MEMORY_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After rst_n is released: ready low for 63 edges, high on edge 64,
    // out zero throughout.
    task automatic sweep(input string tag);
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            check($sformatf("%s_ready_%0d", tag, i), {31'b0, ready}, {31'b0, (i == DEPTH)});
            check($sformatf("%s_out_%0d", tag, i), {16'b0, out}, 32'h0);
        end
    endtask

    task automatic read(input string tag, input logic [AW-1:0] a,
                        input logic [DW-1:0] expected);
        we   = 1'b0;
        addr = a;
        tick();
        check(tag, {16'b0, out}, {16'b0, expected});
    endtask

    task automatic write(input string tag, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] old_value);
        we   = 1'b1;
        addr = a;
        data = d;
        tick();
        check(tag, {16'b0, out}, {16'b0, old_value});
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = '0;
        data  = '0;

        // Reset state
        repeat (3) tick();
        check("rst_out", {16'b0, out}, 32'h0);
        check("rst_ready", {31'b0, ready}, 32'h0);

        // First sweep, with a write to addr 3 attempted the whole time.
        we   = 1'b1;
        addr = 6'd3;
        data = 16'h1234;
        @(negedge clk);
        rst_n = 1'b1;
        sweep("sweep1");
        we = 1'b0;

        // Every word reads zero after the sweep (includes the dropped addr 3).
        for (int a = 0; a < DEPTH; a++) begin
            read($sformatf("clr_rd_%0d", a), AW'(a), 16'h0000);
        end
        check("ready_held", {31'b0, ready}, 32'h1);

        // Read-first write, then read-back, then out follows addr every cycle.
        write("wr8_old", 6'd8, 16'hA5C3, 16'h0000);
        read("rd8_new", 6'd8, 16'hA5C3);
        read("rd9", 6'd9, 16'h0000);
        read("rd8_again", 6'd8, 16'hA5C3);
        write("wr8_over_old", 6'd8, 16'h5A3C, 16'hA5C3);
        read("rd8_over", 6'd8, 16'h5A3C);
        write("wr63_old", 6'd63, 16'hFFFF, 16'h0000);
        read("rd63", 6'd63, 16'hFFFF);
        read("rd3_dropped", 6'd3, 16'h0000);

        // Asynchronous reset while out is non-zero.
        read("rd63_pre_rst", 6'd63, 16'hFFFF);
        rst_n = 1'b0;
        #2;
        check("async_rst_out", {16'b0, out}, 32'h0);
        check("async_rst_ready", {31'b0, ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Partial sweep of 20 cycles, then reset again mid-sweep.
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("part_ready_%0d", i), {31'b0, ready}, 32'h0);
        end
        rst_n = 1'b0;
        tick();
        tick();
        check("mid_rst_ready", {31'b0, ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("sweep2");

        read("rd63_cleared", 6'd63, 16'h0000);
        read("rd8_cleared", 6'd8, 16'h0000);
        read("rd0_cleared", 6'd0, 16'h0000);

`ifdef MEMORY_PARITY_EN
        check("par_initial", {31'b0, parity_err}, 32'h0);
        write("par_wr5", 6'd5, 16'h0007, 16'h0000);
        read("par_rd5", 6'd5, 16'h0007);
        tick();
        tick();
        check("par_clean", {31'b0, parity_err}, 32'h0);

        // Corrupt the stored parity bit of word 5.
        dut.mem[5][DW] = ~dut.mem[5][DW];
        read("par_rd5_bad", 6'd5, 16'h0007);
        tick();
        check("par_err_set", {31'b0, parity_err}, 32'h1);
        addr = 6'd0;
        repeat (3) tick();
        check("par_err_sticky", {31'b0, parity_err}, 32'h1);
        rst_n = 1'b0;
        #2;
        check("par_err_rst", {31'b0, parity_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("sweep3");
        read("par_rd5_cleared", 6'd5, 16'h0000);
        tick();
        tick();
        check("par_after_clear", {31'b0, parity_err}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
